// File: rtl/snake_step_gen.sv
// snake_step_gen: step sequencer feeding the per-digit 7-segment snake ROMs.
// A prescaled base index (0..STEPS-1) plus four phase-shifted addresses, one
// per digit. Supports run / pause / single-step / direction control.
// Optional build macro SNAKE_BOUNCE_EN: the index ping-pongs between its
// ends instead of wrapping, and dir is only latched when leaving IDLE.
module snake_step_gen #(
   parameter int CLK_DIV = 25000000,
   parameter int STEPS   = 20,
   parameter int PHASE   = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       pause,
   input  logic       dir,
   input  logic       step,
   output logic [4:0] addr0,
   output logic [4:0] addr1,
   output logic [4:0] addr2,
   output logic [4:0] addr3,
   output logic       tick,
   output logic       wrap,
   output logic       running
);

   localparam int             PW         = $clog2(CLK_DIV);
   localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [4:0]     BASE_LAST  = 5'(STEPS - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   state_t          state_reg;
   logic [PW-1:0]   presc_reg;
   logic [4:0]      base_reg;
   logic            tick_reg;
   logic            wrap_reg;
   logic            running_reg;
   logic [4:0]      addr_reg [4];

   logic            advance;
   logic [4:0]      adv_base;
   logic            adv_wrap;

   // (base + k*PHASE) mod STEPS. base < STEPS and the constant offset is
   // pre-reduced, so a single conditional subtract finishes the reduction.
   function automatic logic [4:0] mod_add(input logic [4:0] b, input int k);
      logic [6:0] sum;
      sum = 7'(b) + 7'((k * PHASE) % STEPS);
      if (sum >= 7'(STEPS))
         sum = sum - 7'(STEPS);
      return sum[4:0];
   endfunction

   // An advance happens on prescaler expiry in RUN (pause has priority) or on
   // a step pulse in PAUSE; en=0 overrides both.
   assign advance = en && (((state_reg == RUN) && !pause && (presc_reg == PRESC_LAST)) ||
                           ((state_reg == PAUSE) && step));

`ifdef SNAKE_BOUNCE_EN
   logic flag_reg;   // 0 = moving up, 1 = moving down
   logic go_rev;
   logic adv_flag;

   // Bounce arithmetic: move per the flag, turning around on landing at an end.
   always_comb begin
      go_rev = flag_reg;
      if (base_reg == 5'd0)
         go_rev = 1'b0;
      else if (base_reg == BASE_LAST)
         go_rev = 1'b1;
      adv_base = go_rev ? base_reg - 5'd1 : base_reg + 5'd1;
      adv_flag = go_rev;
      adv_wrap = 1'b0;
      if (adv_base == BASE_LAST) begin
         adv_flag = 1'b1;
         adv_wrap = 1'b1;
      end else if (adv_base == 5'd0) begin
         adv_flag = 1'b0;
         adv_wrap = 1'b1;
      end
   end

   // Direction flag: loaded from dir when leaving IDLE, flipped at each end.
   always_ff @(posedge clk) begin
      if (rst || !en)
         flag_reg <= 1'b0;
      else if (state_reg == IDLE)
         flag_reg <= dir;
      else if (advance)
         flag_reg <= adv_flag;
   end
`else
   // Modulo arithmetic: dir is live and sampled in the advance cycle.
   always_comb begin
      adv_wrap = 1'b0;
      if (!dir) begin
         if (base_reg == BASE_LAST) begin
            adv_base = 5'd0;
            adv_wrap = 1'b1;
         end else begin
            adv_base = base_reg + 5'd1;
         end
      end else begin
         if (base_reg == 5'd0) begin
            adv_base = BASE_LAST;
            adv_wrap = 1'b1;
         end else begin
            adv_base = base_reg - 5'd1;
         end
      end
   end
`endif

   // Control FSM: state, prescaler, base index and the registered pulses.
   always_ff @(posedge clk) begin
      tick_reg <= 1'b0;
      wrap_reg <= 1'b0;
      if (rst || !en) begin
         state_reg   <= IDLE;
         presc_reg   <= '0;
         base_reg    <= 5'd0;
         running_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               state_reg   <= RUN;
               running_reg <= 1'b1;
            end
            RUN: begin
               if (pause) begin
                  state_reg   <= PAUSE;
                  running_reg <= 1'b0;
               end else if (presc_reg == PRESC_LAST) begin
                  presc_reg <= '0;
               end else begin
                  presc_reg <= presc_reg + 1'b1;
               end
            end
            PAUSE: begin
               if (!pause) begin
                  state_reg   <= RUN;
                  running_reg <= 1'b1;
               end
            end
            default: begin
               state_reg   <= IDLE;
               running_reg <= 1'b0;
            end
         endcase
         if (advance) begin
            base_reg <= adv_base;
            tick_reg <= 1'b1;
            wrap_reg <= adv_wrap;
         end
      end
   end

   // Per-digit address registers, updated on the same edge as the base.
   for (genvar gi = 0; gi < 4; gi++) begin : g_addr
      always_ff @(posedge clk) begin
         if (rst || !en)
            addr_reg[gi] <= mod_add(5'd0, gi);
         else if (advance)
            addr_reg[gi] <= mod_add(adv_base, gi);
      end
   end

   assign addr0   = addr_reg[0];
   assign addr1   = addr_reg[1];
   assign addr2   = addr_reg[2];
   assign addr3   = addr_reg[3];
   assign tick    = tick_reg;
   assign wrap    = wrap_reg;
   assign running = running_reg;

endmodule

// File: tb/tb_snake_step_gen.sv
// Directed bench for snake_step_gen. Default build: CLK_DIV=4, STEPS=20,
// PHASE=5. With SNAKE_BOUNCE_EN: STEPS=4, PHASE=1, bounce sequence check.
module tb_snake_step_gen;

`ifdef SNAKE_BOUNCE_EN
   localparam int TB_STEPS = 4;
   localparam int TB_PHASE = 1;
`else
   localparam int TB_STEPS = 20;
   localparam int TB_PHASE = 5;
`endif
   localparam int TB_DIV = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       pause = 1'b0;
   logic       dir = 1'b0;
   logic       step = 1'b0;
   logic [4:0] addr0, addr1, addr2, addr3;
   logic       tick, wrap, running;

   int checks = 0;
   int errors = 0;
   int n;

   snake_step_gen #(.CLK_DIV(TB_DIV), .STEPS(TB_STEPS), .PHASE(TB_PHASE)) dut (
      .clk(clk), .rst(rst), .en(en), .pause(pause), .dir(dir), .step(step),
      .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
      .tick(tick), .wrap(wrap), .running(running)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s = %0d", tag, got);
      end
   endtask

   task automatic cyc(input int k);
      repeat (k) @(negedge clk);
   endtask

   // Advance until the next tick (bounded); returns cycles taken.
   task automatic wait_tick(output int cnt);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!tick && cnt < 50);
      check("tick_seen", int'(tick), 1);
   endtask

   task automatic check_addrs(input string tag, input int a0, input int a1,
                              input int a2, input int a3);
      check({tag, "_a0"}, int'(addr0), a0);
      check({tag, "_a1"}, int'(addr1), a1);
      check({tag, "_a2"}, int'(addr2), a2);
      check({tag, "_a3"}, int'(addr3), a3);
   endtask

   initial begin
      cyc(2);
      rst = 1'b0;
`ifndef SNAKE_BOUNCE_EN
      // Reset state
      check_addrs("rst", 0, 5, 10, 15);
      check("rst_tick", int'(tick), 0);
      check("rst_running", int'(running), 0);
      check("rst_wrap", int'(wrap), 0);

      // Enter RUN, first tick CLK_DIV cycles later
      en = 1'b1;
      cyc(1);
      check("run_running", int'(running), 1);
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         check("first_tick_wait", int'(tick), 0);
      end
      cyc(1);
      check("first_tick", int'(tick), 1);
      check("first_wrap", int'(wrap), 0);
      check_addrs("first", 1, 6, 11, 16);

      // Forward up to base 19, then wrap to 0
      for (int i = 0; i < 18; i++) begin
         wait_tick(n);
         check("fwd_spacing", n, 4);
      end
      check("b19_a0", int'(addr0), 19);
      check("b19_a3", int'(addr3), 14);
      check("b19_wrap", int'(wrap), 0);
      wait_tick(n);
      check("wrapfwd_spacing", n, 4);
      check("wrapfwd_wrap", int'(wrap), 1);
      check_addrs("wrapfwd", 0, 5, 10, 15);

      // Reverse from 0 wraps to 19
      dir = 1'b1;
      wait_tick(n);
      check("rev_spacing", n, 4);
      check("rev_wrap", int'(wrap), 1);
      check("rev_a0", int'(addr0), 19);
      check("rev_a1", int'(addr1), 4);
      wait_tick(n);
      check("rev2_a0", int'(addr0), 18);
      check("rev2_wrap", int'(wrap), 0);
      dir = 1'b0;

      // Pause two cycles into a count, two manual steps
      cyc(2);
      pause = 1'b1;
      cyc(1);
      check("pause_running", int'(running), 0);
      for (int i = 0; i < 4; i++) begin
         check("pause_no_tick", int'(tick), 0);
         cyc(1);
      end
      step = 1'b1;
      cyc(1);
      step = 1'b0;
      check("step1_tick", int'(tick), 1);
      check("step1_a0", int'(addr0), 19);
      check("step1_wrap", int'(wrap), 0);
      cyc(1);
      check("step_gap_tick", int'(tick), 0);
      step = 1'b1;
      cyc(1);
      step = 1'b0;
      check("step2_tick", int'(tick), 1);
      check("step2_wrap", int'(wrap), 1);
      check_addrs("step2", 0, 5, 10, 15);
      // Release: one cycle back to RUN, then the remaining 2 prescaler counts
      pause = 1'b0;
      wait_tick(n);
      check("resume_latency", n, 3);
      check("resume_a0", int'(addr0), 1);

      // Pause coincident with prescaler expiry suppresses the advance
      cyc(3);
      pause = 1'b1;
      cyc(1);
      check("pexp_tick", int'(tick), 0);
      check("pexp_a0", int'(addr0), 1);
      cyc(2);
      check("pexp_hold_tick", int'(tick), 0);
      pause = 1'b0;
      wait_tick(n);
      check("pexp_resume_latency", n, 2);
      check("pexp_resume_a0", int'(addr0), 2);

      // en=0 mid-count returns to IDLE with reset addresses
      cyc(2);
      en = 1'b0;
      cyc(1);
      check("idle_running", int'(running), 0);
      check_addrs("idle", 0, 5, 10, 15);
      step = 1'b1;
      cyc(1);
      step = 1'b0;
      check("idle_step_ignored", int'(tick), 0);
      cyc(5);
      check("idle_no_tick", int'(tick), 0);

      // rst while in PAUSE
      en = 1'b1;
      cyc(1);
      check("rerun_running", int'(running), 1);
      cyc(2);
      pause = 1'b1;
      cyc(1);
      step = 1'b1;
      cyc(1);
      step = 1'b0;
      check("prst_step_a0", int'(addr0), 1);
      rst = 1'b1;
      cyc(1);
      check_addrs("prst", 0, 5, 10, 15);
      check("prst_tick", int'(tick), 0);
      check("prst_wrap", int'(wrap), 0);
      check("prst_running", int'(running), 0);
      rst = 1'b0;
      en = 1'b0;
      pause = 1'b0;
      cyc(1);
`else
      begin
         int exp_base [7] = '{1, 2, 3, 2, 1, 0, 1};
         int exp_wrap [7] = '{0, 0, 1, 0, 0, 1, 0};
         check("b_rst_a0", int'(addr0), 0);
         check("b_rst_a1", int'(addr1), 1);
         dir = 1'b0;
         en = 1'b1;
         for (int i = 0; i < 7; i++) begin
            wait_tick(n);
            check("bounce_base", int'(addr0), exp_base[i]);
            check("bounce_a1", int'(addr1), (exp_base[i] + 1) % 4);
            check("bounce_wrap", int'(wrap), exp_wrap[i]);
         end
         en = 1'b0;
         cyc(1);
         check("b_idle_a0", int'(addr0), 0);
      end
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/snake_step_gen.md
Name: snake_step_gen

Overview:
- Sequencer upstream of the per-digit 7-segment snake pattern ROMs.
- Produces a free-running step index and four phase-shifted 5-bit ROM addresses, one per digit, advancing at a prescaled rate.
- The ROM addresses 1-5 and 11-15 are active segments and all others are blank, so the phase offsets make the snake travel across the digits.
- Supports run, pause, single-step and direction control from board switches/buttons; inputs are already debounced and synchronised.

Parameters:
- CLK_DIV, 25000000, clk cycles per step tick; legal range 2..2^26-1.
- STEPS, 20, length of the step sequence; base index runs 0..STEPS-1; legal range 2..32.
- PHASE, 5, address offset between adjacent digits; legal range 0..STEPS-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  run enable; 0 forces IDLE
- pause  in  1  level; freezes stepping while high
- dir  in  1  0 = forward (index +1), 1 = reverse (index -1)
- step  in  1  single-cycle pulse; manual advance in PAUSE only
- addr0  out  5  ROM address, digit 0 = base
- addr1  out  5  (base + PHASE) mod STEPS
- addr2  out  5  (base + 2*PHASE) mod STEPS
- addr3  out  5  (base + 3*PHASE) mod STEPS
- tick  out  1  one-cycle pulse on every base advance, automatic or manual
- wrap  out  1  one-cycle pulse when base wraps, coincident with tick
- running  out  1  high in RUN state

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, rst).
- Reset values:
  - state = IDLE, base = 0, prescaler = 0.
  - addrk = (k*PHASE) mod STEPS.
  - tick = wrap = running = 0.
- States: IDLE, RUN, PAUSE.
  - IDLE: base held at 0, prescaler held at 0. en=1 moves to RUN next cycle.
  - RUN:
    - Prescaler counts 0..CLK_DIV-1.
    - When it reaches CLK_DIV-1: it returns to 0 and base advances (tick=1 the following cycle along with the new addr values).
    - pause=1 moves to PAUSE with the prescaler frozen, not cleared.
  - PAUSE:
    - Prescaler frozen.
    - A step pulse advances base by one.
    - pause=0 returns to RUN and the prescaler resumes from its frozen value.
  - en=0 in any state moves to IDLE next cycle; base and prescaler are cleared there.
- Priority, highest first: rst > en=0 > pause > prescaler expiry.
  - A pause assertion in the same cycle as prescaler expiry suppresses that advance.
  - step is ignored in IDLE and RUN.
- Advance arithmetic:
  - Forward: base==STEPS-1 becomes 0 with wrap=1.
  - Reverse: base==0 becomes STEPS-1 with wrap=1.
  - dir is sampled in the advance cycle; changing dir mid-count does not reset the prescaler.
- Address outputs:
  - Registered; updated in the same edge as base.
  - Computed with 7-bit intermediates and reduced mod STEPS.
  - Always in range 0..STEPS-1.
- Latency: exactly CLK_DIV cycles from entering RUN to the first tick; subsequent ticks are spaced exactly CLK_DIV cycles apart while in RUN.
- running: registered; high exactly while state==RUN.

Optional Feature:
- Macro SNAKE_BOUNCE_EN.
- When defined:
  - Reaching an end (base==STEPS-1 forward, or base==0 reverse) does not wrap.
  - An internal direction flag toggles; base then moves away from that end on the next advance.
  - wrap pulses in the cycle the flag toggles.
  - The dir input only loads the flag on the IDLE-to-RUN transition.
  - Reset and IDLE clear the flag to forward.
- When not defined: modulo wrap as described above; dir is live.

Test Plan:
- Reset, CLK_DIV=4, STEPS=20, PHASE=5: addr0..3 = 0,5,10,15, tick=0, running=0. Raise en: running=1 one cycle later, first tick 4 cycles after entering RUN, addr = 1,6,11,16.
- Forward run for 20 ticks: base 19 wraps to 0 with wrap=1 and tick=1 in the same cycle; addr3 = 14 when base=19, and addr3 = 15 after the wrap.
- dir=1 from base 0: next tick gives base=19 with wrap=1, addr1 = 4.
- pause asserted 2 cycles into a count: no ticks while paused. Two step pulses give two ticks and base +2. Release pause: next tick arrives after the remaining 2 cycles.
- pause and prescaler expiry in the same cycle: no advance. en=0 mid-count: IDLE and addr back to 0,5,10,15 next cycle. rst while in PAUSE: all reset values.
- SNAKE_BOUNCE_EN, STEPS=4, dir=0: base sequence 0,1,2,3,2,1,0,1 with wrap at each end.
